// File: rtl/fast_square_sweep_ctrl.sv
// Frequency-sweep sequencer: steps a synthesizer through L frequencies, gating a
// receiver's clear/record/next-bin strobes, with sync-edge re-arm and pre-emption.
module fast_square_sweep_ctrl #(
  parameter int NUM_STEPS    = 32,
  parameter int STEP_W       = 6,
  parameter int SETTLE_TICKS = 2000,
  parameter int RECORD_TICKS = 35000,
  parameter int PULSE_TICKS  = 64,
  parameter int CNT_W        = 16,
  parameter int SWEEP_CNT_W  = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   sync_in,
  input  logic                   continuous,
  input  logic [STEP_W-1:0]      cfg_steps,
  output logic                   freq_step_out,
  output logic                   rx_reset,
  output logic                   rx_record,
  output logic                   rx_next,
  output logic [STEP_W-1:0]      step_idx,
  output logic                   sweep_done,
  output logic                   resync,
  output logic                   busy,
  output logic [SWEEP_CNT_W-1:0] sweep_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_CLEAR, S_SETTLE, S_RECORD, S_ADVANCE, S_DONE
  } state_t;

  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_TICKS - 1);
  localparam logic [CNT_W-1:0]  RECORD_LAST = CNT_W'(RECORD_TICKS - 1);
  localparam logic [CNT_W-1:0]  PULSE_LAST  = CNT_W'(PULSE_TICKS - 1);
  localparam logic [STEP_W-1:0] MAX_STEPS   = STEP_W'(NUM_STEPS);

  function automatic logic [STEP_W-1:0] eff_steps(input logic [STEP_W-1:0] cfg);
    if (cfg == '0 || cfg > MAX_STEPS) return MAX_STEPS;
    return cfg;
  endfunction

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       tick_q, pcnt_q;
  logic [STEP_W-1:0]      step_q, steps_q;
  logic [SWEEP_CNT_W-1:0] sweep_cnt_q;
  logic                   sync_prev_q;
  logic                   freq_q, rx_reset_q, rx_record_q, rx_next_q;
  logic                   done_q, resync_q, busy_q;
  logic                   sync_edge, in_sweep, last_step, adv_ok, done_evt, preempt;

  always_comb begin
    sync_edge = sync_in & ~sync_prev_q;
    in_sweep  = (state_q == S_SETTLE) || (state_q == S_RECORD) || (state_q == S_ADVANCE);
    preempt   = in_sweep && sync_edge;
    last_step = (step_q == steps_q - 1'b1);
    adv_ok    = enable && (state_q == S_ADVANCE) && !sync_edge;
    done_evt  = adv_ok && last_step;
    state_d   = state_q;
    case (state_q)
      S_IDLE:    if (enable) state_d = S_ARM;
      S_ARM:     if (sync_edge) state_d = S_CLEAR;
      S_CLEAR:   state_d = S_SETTLE;
      S_SETTLE:  if (tick_q == SETTLE_LAST) state_d = S_RECORD;
      S_RECORD:  if (tick_q == RECORD_LAST) state_d = S_ADVANCE;
      S_ADVANCE: state_d = !last_step ? S_SETTLE : (continuous ? S_ARM : S_DONE);
      S_DONE:    state_d = S_DONE;
      default:   state_d = S_IDLE;
    endcase
    // Priority: enable drop beats a sync pre-emption, which beats normal sequencing.
    if (preempt) state_d = S_CLEAR;
    if (!enable) state_d = S_IDLE;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      tick_q      <= '0;
      pcnt_q      <= '0;
      step_q      <= '0;
      steps_q     <= MAX_STEPS;
      sweep_cnt_q <= '0;
      sync_prev_q <= 1'b0;
      freq_q      <= 1'b0;
      rx_reset_q  <= 1'b0;
      rx_record_q <= 1'b0;
      rx_next_q   <= 1'b0;
      done_q      <= 1'b0;
      resync_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_prev_q <= sync_in;
      if (state_d == state_q && (state_q == S_SETTLE || state_q == S_RECORD))
        tick_q <= tick_q + 1'b1;
      else
        tick_q <= '0;
      if (state_q == S_CLEAR) steps_q <= eff_steps(cfg_steps);
      if (state_d == S_CLEAR) step_q <= '0;
      else if (adv_ok && !last_step) step_q <= step_q + 1'b1;
      if (done_evt) sweep_cnt_q <= sweep_cnt_q + 1'b1;
      done_q      <= done_evt;
      resync_q    <= enable && preempt;
      // Outputs are decoded from the next state so they line up with state_q.
      rx_reset_q  <= (state_d == S_CLEAR);
      rx_record_q <= (state_d == S_RECORD);
      rx_next_q   <= (state_d == S_ADVANCE);
      busy_q      <= (state_d == S_CLEAR) || (state_d == S_SETTLE) ||
                     (state_d == S_RECORD) || (state_d == S_ADVANCE);
      if (!enable) begin
        freq_q <= 1'b0;
        pcnt_q <= '0;
      end else if (adv_ok) begin
        freq_q <= 1'b1;
        pcnt_q <= PULSE_LAST;
      end else if (pcnt_q != '0) begin
        pcnt_q <= pcnt_q - 1'b1;
      end else begin
        freq_q <= 1'b0;
      end
    end
  end

  assign freq_step_out = freq_q;
  assign rx_reset      = rx_reset_q;
  assign rx_record     = rx_record_q;
  assign rx_next       = rx_next_q;
  assign step_idx      = step_q;
  assign sweep_done    = done_q;
  assign resync        = resync_q;
  assign busy          = busy_q;
  assign sweep_count   = sweep_cnt_q;

endmodule

// File: tb/tb_fast_square_sweep_ctrl.sv
// Bench for fast_square_sweep_ctrl: directed table, corner sequences and a random
// run against an offset-arithmetic reference of the sweep timeline.
module tb_fast_square_sweep_ctrl;
  localparam int NS = 4, SW = 3, ST = 3, RT = 5, PT = 2, CW = 4, SCW = 16;
  localparam int PER = ST + RT + 1;

  logic clock = 1'b0, reset = 1'b0, enable = 1'b0, sync_in = 1'b0, continuous = 1'b0;
  logic [SW-1:0]  cfg_steps = '0;
  logic           freq_step_out, rx_reset, rx_record, rx_next, sweep_done, resync, busy;
  logic [SW-1:0]  step_idx;
  logic [SCW-1:0] sweep_count;

  always #5 clock = ~clock;

  fast_square_sweep_ctrl #(
    .NUM_STEPS(NS), .STEP_W(SW), .SETTLE_TICKS(ST), .RECORD_TICKS(RT),
    .PULSE_TICKS(PT), .CNT_W(CW), .SWEEP_CNT_W(SCW)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .sync_in(sync_in),
    .continuous(continuous), .cfg_steps(cfg_steps), .freq_step_out(freq_step_out),
    .rx_reset(rx_reset), .rx_record(rx_record), .rx_next(rx_next), .step_idx(step_idx),
    .sweep_done(sweep_done), .resync(resync), .busy(busy), .sweep_count(sweep_count)
  );

  int checks = 0, failures = 0;

  // Reference: mode 0 idle, 1 armed, 2 sweeping, 3 done; m_off = cycles since CLEAR entry.
  int m_mode = 0, m_off = 0, m_L = NS, m_step = 0, m_prev = 0, m_prem = 0, m_cnt = 0;
  int m_done = 0, m_res = 0;

  function automatic logic [25:0] dut_vec();
    return {freq_step_out, rx_reset, rx_record, rx_next, busy, sweep_done, resync,
            step_idx, sweep_count};
  endfunction

  function automatic logic [25:0] vec(logic [6:0] flags, int step, int cnt);
    return {flags, SW'(step), SCW'(cnt)};
  endfunction

  function automatic logic [25:0] model_vec();
    int ph;
    bit sw, clr, rec, nxt;
    sw  = (m_mode == 2);
    clr = sw && (m_off == 0);
    ph  = (m_off > 0) ? (m_off - 1) % PER : 0;
    rec = sw && (m_off > 0) && (ph >= ST) && (ph < ST + RT);
    nxt = sw && (m_off > 0) && (ph == PER - 1);
    return {m_prem > 0, clr, rec, nxt, sw, m_done == 1, m_res == 1, SW'(m_step), SCW'(m_cnt)};
  endfunction

  task automatic model_clock(bit rn, bit en, bit sy, bit co, int cfg);
    bit edge_s, adv;
    int ph, k;
    if (!rn) begin
      m_mode = 0; m_off = 0; m_step = 0; m_prev = 0; m_prem = 0; m_cnt = 0;
      m_done = 0; m_res = 0;
      return;
    end
    edge_s = sy && (m_prev == 0);
    m_prev = sy;
    m_done = 0; m_res = 0; adv = 0;
    ph = (m_off > 0) ? (m_off - 1) % PER : 0;
    k  = (m_off > 0) ? (m_off - 1) / PER : 0;
    if (!en) m_mode = 0;
    else case (m_mode)
      0: m_mode = 1;
      1: if (edge_s) begin m_mode = 2; m_off = 0; m_step = 0; end
      2: begin
        if (m_off == 0) begin
          m_L = (cfg == 0 || cfg > NS) ? NS : cfg;
          m_off = 1;
        end else if (edge_s) begin
          m_res = 1; m_off = 0; m_step = 0;
        end else if (ph == PER - 1) begin
          adv = 1;
          if (k == m_L - 1) begin
            m_done = 1; m_cnt = (m_cnt + 1) % 65536; m_mode = co ? 1 : 3;
          end else begin
            m_off++; m_step = k + 1;
          end
        end else m_off++;
      end
      default: m_mode = 3;
    endcase
    if (!en) m_prem = 0;
    else if (adv) m_prem = PT;
    else if (m_prem > 0) m_prem--;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick(bit rn, bit en, bit sy, bit co, int cfg);
    reset = rn; enable = en; sync_in = sy; continuous = co; cfg_steps = SW'(cfg);
    @(posedge clock);
    model_clock(rn, en, sy, co, cfg);
    #1;
    check("model", dut_vec(), model_vec());
  endtask

  typedef struct { bit en; bit sy; bit co; int cfg; int n; logic [25:0] exp; } rec_t;
  rec_t tbl[$];

  task automatic add(bit en, bit sy, bit co, int cfg, int n, logic [6:0] f, int s, int c);
    rec_t r;
    r.en = en; r.sy = sy; r.co = co; r.cfg = cfg; r.n = n; r.exp = vec(f, s, c);
    tbl.push_back(r);
  endtask

  initial begin
    int c, found;
    logic [7:0] seq;
    bit rs, rco;

    add(1, 0, 0, 0, 2,  7'b0000000, 0, 0);
    add(1, 1, 0, 0, 1,  7'b0100100, 0, 0);
    add(1, 1, 0, 0, 1,  7'b0000100, 0, 0);
    add(1, 1, 0, 1, 3,  7'b0010100, 0, 0);
    add(1, 1, 0, 1, 5,  7'b0001100, 0, 0);
    add(1, 1, 0, 1, 1,  7'b1000100, 1, 0);
    add(1, 1, 0, 1, 1,  7'b1000100, 1, 0);
    add(1, 1, 0, 1, 1,  7'b0000100, 1, 0);
    add(1, 1, 0, 1, 24, 7'b0001100, 3, 0);
    add(1, 1, 0, 1, 1,  7'b1000010, 3, 1);
    add(1, 1, 0, 1, 1,  7'b1000000, 3, 1);
    add(1, 1, 0, 1, 3,  7'b0000000, 3, 1);
    add(1, 0, 0, 1, 1,  7'b0000000, 3, 1);
    add(1, 1, 0, 1, 1,  7'b0000000, 3, 1);
    add(0, 1, 0, 1, 1,  7'b0000000, 3, 1);
    add(1, 1, 0, 1, 2,  7'b0000000, 3, 1);
    add(1, 0, 0, 7, 1,  7'b0000000, 3, 1);
    add(1, 1, 0, 7, 1,  7'b0100100, 0, 1);
    add(1, 1, 0, 7, 1,  7'b0000100, 0, 1);
    add(1, 1, 0, 2, 35, 7'b0001100, 3, 1);
    add(1, 1, 0, 2, 1,  7'b1000010, 3, 2);

    repeat (3) tick(0, 0, 0, 0, 0);
    check("reset_state", dut_vec(), 26'd0);
    foreach (tbl[i]) begin
      repeat (tbl[i].n) tick(1, tbl[i].en, tbl[i].sy, tbl[i].co, tbl[i].cfg);
      check($sformatf("table%0d", i), dut_vec(), tbl[i].exp);
    end

    // Continuous two-step sweeps.
    repeat (2) tick(0, 0, 0, 0, 0);
    repeat (2) tick(1, 1, 0, 1, 2);
    seq = '0;
    for (int s = 0; s < 2; s++) begin
      tick(1, 1, 0, 1, 2);
      tick(1, 1, 1, 1, 2);
      c = 0;
      while (!sweep_done && c < 60) begin
        tick(1, 1, 1, 1, 2);
        c++;
        if (rx_next) seq = {seq[5:0], 2'(step_idx)};
      end
      check($sformatf("cont_len%0d", s), c, 19);
    end
    check("cont_steps", seq, 8'b00010001);
    check("cont_count", sweep_count, 2);

    // Pre-emption during step 2 record.
    repeat (2) tick(0, 0, 0, 0, 0);
    repeat (2) tick(1, 1, 0, 0, 0);
    tick(1, 1, 1, 0, 0);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick(1, 1, 0, 0, 0);
      if (rx_record && step_idx == 2) found = 1;
    end
    check("resync_reach", found, 1);
    tick(1, 1, 1, 0, 0);
    check("resync_pulse", dut_vec(), vec(7'b0100101, 0, 0));
    tick(1, 1, 1, 0, 0);
    check("resync_after", dut_vec(), vec(7'b0000100, 0, 0));

    // Enable drop in SETTLE, then re-enable with sync held high.
    tick(1, 0, 1, 0, 0);
    check("en_drop", dut_vec(), 26'd0);
    repeat (4) tick(1, 1, 1, 0, 0);
    check("en_rearm_wait", dut_vec(), 26'd0);

    // Reset in the middle of a freq_step_out pulse with sync held high.
    tick(1, 1, 0, 0, 0);
    tick(1, 1, 1, 0, 0);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1, 1, 1, 0, 0);
      if (freq_step_out) found = 1;
    end
    check("pulse_reach", found, 1);
    repeat (2) tick(0, 1, 1, 0, 0);
    check("reset_midpulse", dut_vec(), 26'd0);
    repeat (5) tick(1, 1, 1, 0, 0);
    check("reset_nosync", dut_vec(), 26'd0);
    tick(1, 1, 0, 0, 0);
    tick(1, 1, 1, 0, 0);
    check("reset_resync", dut_vec(), vec(7'b0100100, 0, 0));

    // Randomized run against the reference.
    rs = 0; rco = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) rs = ~rs;
      if ($urandom_range(0, 99) == 0) rco = ~rco;
      tick($urandom_range(0, 299) != 0, $urandom_range(0, 49) != 0, rs, rco,
           $urandom_range(0, 7));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
